// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix / seven-segment scanner.
package led_scan_pkg;

    // Eight matrix rows plus one seven-segment digit share the scan.
    localparam int NUM_ROWS  = 8;
    localparam int NUM_SLOTS = 9;
    localparam int SEG_SLOT  = 8;

    // Number of brightness steps in the active part of a slot.
    localparam int NUM_STEPS = 16;

    typedef logic [3:0] slot_idx_t;
    typedef logic [7:0] frame_row_t;

    // Active-low row enable pattern for a slot; the segment slot drives no row.
    function automatic frame_row_t row_enable(input slot_idx_t slot);
        frame_row_t r;
        r = '1;
        if (slot < slot_idx_t'(NUM_ROWS)) begin
            r[slot[2:0]] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_scan_timing.sv
// Slot and in-slot cycle counters for the scanner. Produces the current slot
// index, whether the current cycle is lit for the latched brightness, and
// strobes for the first cycle of a frame and the last cycle of a frame.
module led_scan_timing
    import led_scan_pkg::*;
#(
    parameter int BLANK_CYCLES = 27,
    parameter int STEP_CYCLES  = 165
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] brightness,
    output slot_idx_t  slot,
    output logic       slot_start,
    output logic       lit,
    output logic       frame_start,
    output logic       frame_end
);

    localparam int SLOT_CYCLES = BLANK_CYCLES + NUM_STEPS * STEP_CYCLES;
    localparam int CW          = $clog2(SLOT_CYCLES + 1);

    logic [CW-1:0] cyc;
    logic [3:0]    bright_q;
    logic [3:0]    bright_eff;
    logic [CW-1:0] on_len;
    logic [CW-1:0] active_cyc;
    logic          last_cyc;

    assign last_cyc    = (cyc == CW'(SLOT_CYCLES - 1));
    assign slot_start  = (cyc == '0);
    assign frame_start = slot_start && (slot == '0);
    assign frame_end   = last_cyc && (slot == slot_idx_t'(SEG_SLOT));

    // Cycle counter runs through one slot, then the slot index advances and wraps after the segment slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc  <= '0;
            slot <= '0;
        end else if (last_cyc) begin
            cyc  <= '0;
            slot <= (slot == slot_idx_t'(SEG_SLOT)) ? '0 : slot + slot_idx_t'(1);
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    // Brightness is captured once per slot so a slot never changes duty mid-way.
    always_ff @(posedge clock) begin
        if (reset) begin
            bright_q <= '0;
        end else if (slot_start) begin
            bright_q <= brightness;
        end
    end

    // On the capture cycle itself the fresh value is used, so a zero-length
    // blanking interval still sees the new brightness.
    assign bright_eff = slot_start ? brightness : bright_q;
    assign on_len     = CW'(STEP_CYCLES) * CW'(bright_eff);
    assign active_cyc = cyc - CW'(BLANK_CYCLES);
    assign lit        = (cyc >= CW'(BLANK_CYCLES)) && (active_cyc < on_len);

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed driver for an 8x8 LED matrix plus one seven-segment digit.
// Double-buffered: writes land in the back bank, and a commit swaps banks at
// the next frame boundary so a frame is never displayed half-updated.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int BLANK_CYCLES = 27,
    parameter int STEP_CYCLES  = 165
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit,
    input  logic [3:0] brightness,
    output logic [7:0] row,
    output logic [7:0] d,
    output logic       seven_seg,
    output logic       commit_pending,
    output logic       frame_start
);

    frame_row_t bank0 [NUM_SLOTS];
    frame_row_t bank1 [NUM_SLOTS];

    // 0: bank0 is displayed and bank1 receives writes; 1: the reverse.
    logic       front_sel;
    logic       ready_q;

    slot_idx_t  slot;
    logic       slot_start;
    logic       lit;
    logic       scan_frame_start;
    logic       frame_end;

    logic       swap;
    logic       wr_fire;
    logic       wr_hit;
    frame_row_t front_row;

    led_scan_timing #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .STEP_CYCLES  (STEP_CYCLES)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .brightness  (brightness),
        .slot        (slot),
        .slot_start  (slot_start),
        .lit         (lit),
        .frame_start (scan_frame_start),
        .frame_end   (frame_end)
    );

    // The swap happens on the last cycle of the segment slot; writes are held
    // off in that cycle so none can land in a bank that is changing role.
    assign swap     = frame_end && commit_pending;
    assign wr_ready = ready_q && !reset && !swap;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_hit   = wr_fire && (wr_addr <= slot_idx_t'(SEG_SLOT));

    assign front_row = front_sel ? bank1[slot] : bank0[slot];

    // Back-bank writes; addresses past the segment byte are accepted and dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_hit) begin
            if (front_sel) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    // Bank select, pending-commit flag and the post-reset ready hold-off.
    always_ff @(posedge clock) begin
        if (reset) begin
            front_sel      <= 1'b0;
            commit_pending <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (swap) begin
                front_sel      <= ~front_sel;
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            row         <= '1;
            d           <= '0;
            seven_seg   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= scan_frame_start;
            if (!lit) begin
                row       <= '1;
                d         <= '0;
                seven_seg <= 1'b0;
            end else if (slot == slot_idx_t'(SEG_SLOT)) begin
                row       <= '1;
                d         <= front_row;
                seven_seg <= 1'b1;
            end else begin
                row       <= row_enable(slot);
                d         <= front_row;
                seven_seg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with short slots (2 blank + 16 x 1).
module tb_led_matrix_scanner;

    localparam int BLK  = 2;
    localparam int STP  = 1;
    localparam int SLOT = BLK + 16 * STP;
    localparam int FR   = 9 * SLOT;

    logic       clock;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic [3:0] brightness;
    logic [7:0] row;
    logic [7:0] d;
    logic       seven_seg;
    logic       commit_pending;
    logic       frame_start;

    led_matrix_scanner #(
        .BLANK_CYCLES (BLK),
        .STEP_CYCLES  (STP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .brightness     (brightness),
        .row            (row),
        .d              (d),
        .seven_seg      (seven_seg),
        .commit_pending (commit_pending),
        .frame_start    (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_cmp;
    int         n_bad;
    int         t;
    logic [7:0] efront [9];
    logic [7:0] eback  [9];
    logic [3:0] eb;
    logic       epend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock; the outputs then show the scan position with index t.
    task automatic step();
        logic [3:0]  bprev;
        logic [16:0] ex;
        logic [7:0]  rb;
        logic [7:0]  tmp;
        int          f;
        int          s;
        int          c;
        bprev = brightness;
        @(posedge clock);
        #1;
        t++;
        f = t % FR;
        s = f / SLOT;
        c = f % SLOT;
        if (c == 0) eb = bprev;
        rb = 8'h01;
        rb = ~(rb << s);
        if (c < BLK || (c - BLK) >= int'(eb) * STP) ex = {8'hFF, 8'h00, 1'b0};
        else if (s < 8)                             ex = {rb, efront[s], 1'b0};
        else                                        ex = {8'hFF, efront[8], 1'b1};
        chk("out", 32'({row, d, seven_seg}), 32'(ex));
        chk("fstart", 32'(frame_start), 32'(f == 0));
        if (f == 160) chk("rdy_swapcyc", 32'(wr_ready), 32'(!epend));
        if (f == 161 && epend) begin
            chk("pend_clr", 32'(commit_pending), 32'd0);
            for (int i = 0; i < 9; i++) begin
                tmp       = efront[i];
                efront[i] = eback[i];
                eback[i]  = tmp;
            end
            epend = 1'b0;
        end
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        chk("rdy", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = v;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic cmt();
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("pend_set", 32'(commit_pending), 32'd1);
        epend = 1'b1;
    endtask

    task automatic model_reset();
        t     = -1;
        eb    = 4'd0;
        epend = 1'b0;
        for (int i = 0; i < 9; i++) begin
            efront[i] = 8'h00;
            eback[i]  = 8'h00;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk({tag, "_out"}, 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
        chk({tag, "_rdy"}, 32'(wr_ready), 32'd0);
        chk({tag, "_pend"}, 32'(commit_pending), 32'd0);
        reset = 1'b0;
        chk({tag, "_rdy_after"}, 32'(wr_ready), 32'd0);
        chk({tag, "_fs_after"}, 32'(frame_start), 32'd0);
        chk({tag, "_out_after"}, 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        t          = -1;
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 8'd0;
        commit     = 1'b0;
        brightness = 4'd15;
        model_reset();
        do_reset("rst0");

        // Frame 0: empty front at full brightness; stage A5 into row 3.
        run_to(10);
        wr(4'd3, 8'hA5);
        eback[3] = 8'hA5;
        run_to(20);
        cmt();
        run_to(162);

        // Frame 1: row 3 lit for 15 cycles after 2 blank cycles.
        run_to(217);
        chk("s3_blank", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        run_to(218);
        chk("s3_first", 32'({row, d, seven_seg}), 32'({8'hF7, 8'hA5, 1'b0}));
        run_to(232);
        chk("s3_last", 32'({row, d, seven_seg}), 32'({8'hF7, 8'hA5, 1'b0}));
        run_to(233);
        chk("s3_off", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        run_to(240);
        brightness = 4'd4;
        run_to(250);
        wr(4'd8, 8'h3F);
        eback[8] = 8'h3F;
        run_to(259);
        cmt();
        run_to(299);
        cmt();
        run_to(324);
        chk("pend_after_swap", 32'(commit_pending), 32'd0);

        // Frame 2: segment byte 3F for exactly 4 cycles; old row 3 now in back.
        run_to(380);
        chk("s3_empty", 32'({row, d, seven_seg}), 32'({8'hF7, 8'h00, 1'b0}));
        run_to(400);
        wr(4'd12, 8'hFF);
        run_to(420);
        cmt();
        run_to(470);
        chk("seg_first", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h3F, 1'b1}));
        run_to(473);
        chk("seg_last", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h3F, 1'b1}));
        run_to(474);
        chk("seg_off", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));

        // Frame 3: previous front returns without a copy; address 12 left no trace.
        run_to(542);
        chk("s3_back", 32'({row, d, seven_seg}), 32'({8'hF7, 8'hA5, 1'b0}));
        run_to(546);
        chk("s3_b4_off", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        run_to(632);
        chk("seg_zero", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b1}));
        run_to(643);
        brightness = 4'd0;

        // Frame 4: brightness 0 keeps every slot dark; reset lands in slot 5.
        run_to(700);
        cmt();
        run_to(704);
        chk("dark_s3", 32'({row, d, seven_seg}), 32'({8'hFF, 8'h00, 1'b0}));
        run_to(743);
        chk("pend_pre_rst", 32'(commit_pending), 32'd1);
        brightness = 4'd15;
        do_reset("rst1");

        // After reset both banks read back empty and scanning restarts at slot 0.
        run_to(19);
        cmt();
        run_to(324);
        chk("pend_end", 32'(commit_pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
